// File: rtl/ram_pkg.sv
// Shared types and the byte-lane rotation helper for the unaligned single-port test RAM.
package ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } ram_state_e;

    // Widest word the rotation helper can handle; callers zero-extend into it and truncate back.
    localparam int unsigned LANE_MAX_W = 1024;
    localparam int unsigned LANE_IDX_W = $clog2(LANE_MAX_W);

    typedef logic [LANE_MAX_W-1:0] lane_vec_t;

    // Rotate the low nb bytes of data upward by off lanes: byte k lands in lane (k+off) mod nb.
    function automatic lane_vec_t lane_rotate(input lane_vec_t data, input int unsigned nb,
                                              input int unsigned off);
        lane_vec_t             res;
        logic [LANE_IDX_W-1:0] src;
        logic [LANE_IDX_W-1:0] dst;
        res = '0;
        for (int unsigned k = 0; k < LANE_MAX_W / 8; k++) begin
            if (k < nb) begin
                src = LANE_IDX_W'(k * 8);
                dst = LANE_IDX_W'(((k + off) % nb) * 8);
                res[dst +: 8] = data[src +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_bank.sv
// Word-wide single-port storage array with per-byte write enables and a registered,
// read-first data output.
module ram_bank #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter string       INIT_FILE = "",
  localparam int unsigned NB       = DATA_W / 8,
  localparam int unsigned IDX_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [NB-1:0]     be_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  (* ram_style = "block" *) logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // The read samples the array before the same-edge byte writes take effect.
  always_ff @(posedge clk) begin
    if (en_i) begin
      rdata_q <= mem_q[idx_i];
      if (we_i) begin
        for (int b = 0; b < NB; b++) begin
          if (be_i[b]) begin
            mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
          end
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_sp_unaligned.sv
// Single-port test RAM with req/gnt/rvalid handshake, byte strobes and unaligned byte
// addressing; accesses crossing a word boundary are served as two consecutive word beats.
module ram_sp_unaligned #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned ADDR_W    = 32,
    parameter string       INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                rstn_i,
    input  logic                req_i,
    output logic                gnt_o,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic                rvalid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                err_o
);

    import ram_pkg::*;

    localparam int unsigned NB     = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(NB);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned WIDX_W = ADDR_W - OFF_W;
    localparam logic [WIDX_W-1:0] DEPTH_W = WIDX_W'(DEPTH);
    localparam logic [WIDX_W-1:0] LAST_W  = WIDX_W'(DEPTH - 1);

    // Handshake: a request transfers on a rising clk edge where req_i && gnt_o; the requester
    // holds req_i and its payload until then. Each transfer yields exactly one rvalid_o pulse,
    // in request order, with rdata_o/err_o valid only while rvalid_o is high.

    // Request decode
    logic [OFF_W-1:0]  off;
    logic [WIDX_W-1:0] widx;
    logic [DATA_W-1:0] wdata_rot;
    logic [DATA_W-1:0] be_bytes;
    logic [DATA_W-1:0] be_bytes_rot;
    logic [NB-1:0]     be_rot;
    logic [NB-1:0]     lo_mask;
    logic              split;
    logic              req_err;
    logic              accept;

    // FSM and latched request
    ram_state_e        state_q,  state_d;
    logic              rvalid_q, rvalid_d;
    logic              we_q,     we_d;
    logic              err_q,    err_d;
    logic              split_q,  split_d;
    logic [OFF_W-1:0]  off_q,    off_d;
    logic [IDX_W-1:0]  idx_q,    idx_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [NB-1:0]     be_q,     be_d;
    logic [DATA_W-1:0] word0_q,  word0_d;
    logic [NB-1:0]     lat_lo_mask;

    // Bank port
    logic              bank_en;
    logic              bank_we;
    logic [IDX_W-1:0]  bank_idx;
    logic [NB-1:0]     bank_be;
    logic [DATA_W-1:0] bank_wdata;
    logic [DATA_W-1:0] bank_rdata;

    // Read path
    logic [DATA_W-1:0] merged;
    logic [OFF_W-1:0]  rd_rot;
    logic [DATA_W-1:0] rdata_aligned;

    assign off    = addr_i[OFF_W-1:0];
    assign widx   = addr_i[ADDR_W-1:OFF_W];
    assign gnt_o  = (state_q == IDLE);
    assign accept = req_i && gnt_o;

    // Lanes below the offset belong to the second word of a straddling access.
    always_comb begin
        be_bytes = '0;
        be_rot   = '0;
        lo_mask  = '0;
        for (int b = 0; b < NB; b++) begin
            be_bytes[b*8 +: 8] = {8{be_i[b]}};
        end
        wdata_rot    = DATA_W'(lane_rotate(LANE_MAX_W'(wdata_i), NB, 32'(off)));
        be_bytes_rot = DATA_W'(lane_rotate(LANE_MAX_W'(be_bytes), NB, 32'(off)));
        for (int b = 0; b < NB; b++) begin
            be_rot[b]  = |be_bytes_rot[b*8 +: 8];
            lo_mask[b] = (OFF_W'(b) < off);
        end
        split   = we_i ? |(be_rot & lo_mask) : (off != '0);
        req_err = (widx >= DEPTH_W) || (split && (widx >= LAST_W));
    end

    always_comb begin
        lat_lo_mask = '0;
        for (int b = 0; b < NB; b++) begin
            lat_lo_mask[b] = (OFF_W'(b) < off_q);
        end
    end

    // An erroring access never enables the bank, so neither beat can write.
    always_comb begin
        bank_en    = 1'b0;
        bank_we    = 1'b0;
        bank_idx   = '0;
        bank_be    = '0;
        bank_wdata = wdata_rot;
        if (state_q == IDLE) begin
            if (accept && !req_err) begin
                bank_en  = 1'b1;
                bank_we  = we_i;
                bank_idx = widx[IDX_W-1:0];
                bank_be  = be_rot & ~lo_mask;
            end
        end else if (!err_q) begin
            bank_en    = 1'b1;
            bank_we    = we_q;
            bank_idx   = idx_q + IDX_W'(1);
            bank_be    = be_q & lat_lo_mask;
            bank_wdata = wdata_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        rvalid_d = 1'b0;
        we_d     = we_q;
        err_d    = err_q;
        split_d  = split_q;
        off_d    = off_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        word0_d  = word0_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = we_i;
                    err_d   = req_err;
                    split_d = split;
                    off_d   = off;
                    idx_d   = widx[IDX_W-1:0];
                    wdata_d = wdata_rot;
                    be_d    = be_rot;
                    if (split) begin
                        state_d = SPLIT;
                    end else begin
                        rvalid_d = 1'b1;
                    end
                end
            end
            SPLIT: begin
                word0_d  = bank_rdata;
                rvalid_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            rvalid_q <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            split_q  <= 1'b0;
            off_q    <= '0;
            idx_q    <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            word0_q  <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rvalid_d;
            we_q     <= we_d;
            err_q    <= err_d;
            split_q  <= split_d;
            off_q    <= off_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            word0_q  <= word0_d;
        end
    end

    // Reassemble the memory view in lane order, then rotate it back so byte k is addr+k.
    always_comb begin
        merged = '0;
        for (int b = 0; b < NB; b++) begin
            merged[b*8 +: 8] = (split_q && !lat_lo_mask[b]) ? word0_q[b*8 +: 8]
                                                            : bank_rdata[b*8 +: 8];
        end
        rd_rot        = -off_q;
        rdata_aligned = DATA_W'(lane_rotate(LANE_MAX_W'(merged), NB, 32'(rd_rot)));
    end

    assign rvalid_o = rvalid_q;
    assign err_o    = rvalid_q && err_q;
    assign rdata_o  = (rvalid_q && !we_q && !err_q) ? rdata_aligned : '0;

    ram_bank #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .INIT_FILE(INIT_FILE)
    ) u_bank (
        .clk    (clk),
        .en_i   (bank_en),
        .we_i   (bank_we),
        .idx_i  (bank_idx),
        .be_i   (bank_be),
        .wdata_i(bank_wdata),
        .rdata_o(bank_rdata)
    );

endmodule

// File: tb/tb_ram_sp_unaligned.sv
// Bench for ram_sp_unaligned: byte-addressed reference memory, expected-response queue with
// response-cycle prediction, directed boundary cases and randomized traffic.
module tb_ram_sp_unaligned;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 16;
    localparam int ADDR_W    = 32;
    localparam int NB        = DATA_W / 8;
    localparam int MEM_BYTES = DEPTH * NB;

    logic              clk = 1'b0;
    logic              rstn_i;
    logic              req_i;
    logic              gnt_o;
    logic [ADDR_W-1:0] addr_i;
    logic              we_i;
    logic [NB-1:0]     be_i;
    logic [DATA_W-1:0] wdata_i;
    logic              rvalid_o;
    logic [DATA_W-1:0] rdata_o;
    logic              err_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0]        mem_m [MEM_BYTES];
    logic [DATA_W:0]   exp_q[$];
    int                exp_cyc_q[$];

    ram_sp_unaligned #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .INIT_FILE("")
    ) dut (
        .clk     (clk),
        .rstn_i  (rstn_i),
        .req_i   (req_i),
        .gnt_o   (gnt_o),
        .addr_i  (addr_i),
        .we_i    (we_i),
        .be_i    (be_i),
        .wdata_i (wdata_i),
        .rvalid_o(rvalid_o),
        .rdata_o (rdata_o),
        .err_o   (err_o)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: plain byte-addressed memory; returns {err, rdata} and extra response delay.
    task automatic model(input logic [31:0] a, input logic we, input logic [3:0] be,
                         input logic [31:0] wd, output logic [DATA_W:0] e, output int lat);
        longint unsigned widx;
        int              off;
        bit              split;
        bit              err;
        logic [31:0]     rd;
        widx  = longint'(a) >> 2;
        off   = int'(a[1:0]);
        rd    = '0;
        split = 1'b0;
        if (we) begin
            for (int k = 0; k < NB; k++) if (be[k] && (off + k >= NB)) split = 1'b1;
        end else begin
            split = (off != 0);
        end
        err = (widx >= DEPTH) || (split && (widx + 1 >= DEPTH));
        if (!err) begin
            for (int k = 0; k < NB; k++) begin
                if (we && be[k]) mem_m[int'(a) + k] = wd[k*8 +: 8];
                else if (!we)    rd[k*8 +: 8] = mem_m[int'(a) + k];
            end
        end
        e   = {err, rd};
        lat = split ? 1 : 0;
    endtask

    // Driver: present a request, hold it until granted, record expectation, drop req.
    task automatic issue(input logic [31:0] a, input logic we, input logic [3:0] be,
                         input logic [31:0] wd);
        int              n;
        int              lat;
        logic [DATA_W:0] e;
        @(negedge clk);
        req_i   = 1'b1;
        addr_i  = a;
        we_i    = we;
        be_i    = be;
        wdata_i = wd;
        n = 0;
        while (!gnt_o && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n >= 8) check("gnt_timeout", 64'(gnt_o), 64'd1);
        model(a, we, be, wd, e, lat);
        exp_q.push_back(e);
        exp_cyc_q.push_back(cyc + 1 + lat);
        @(posedge clk);
        #1 req_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        #1 check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: every rvalid pulse must match the oldest expectation, data and cycle.
    always @(negedge clk) begin
        if (rstn_i && rvalid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 64'(rvalid_o), 64'd0);
            end else begin
                logic [DATA_W:0] e;
                int              ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("rsp_err_rdata", 64'({err_o, rdata_o}), 64'(e));
                check("rsp_cycle", 64'(cyc), 64'(ec));
            end
        end
    end

    initial begin
        logic [31:0] wd;
        logic [31:0] a;

        rstn_i  = 1'b0;
        req_i   = 1'b0;
        addr_i  = '0;
        we_i    = 1'b0;
        be_i    = '0;
        wdata_i = '0;
        repeat (3) @(negedge clk);
        check("reset_rvalid", 64'(rvalid_o), 64'd0);
        check("reset_err", 64'(err_o), 64'd0);
        check("reset_rdata", 64'(rdata_o), 64'd0);
        check("reset_gnt", 64'(gnt_o), 64'd1);
        rstn_i = 1'b1;

        for (int w = 0; w < DEPTH; w++) issue(32'(w * 4), 1'b1, 4'hF, $urandom);
        drain();

        // Aligned write then read back
        issue(32'h8, 1'b1, 4'hF, 32'h11223344);
        issue(32'h8, 1'b0, 4'h0, 32'h0);
        drain();

        // Straddling read: grant drops for the second beat
        issue(32'h4, 1'b1, 4'hF, 32'hAABBCCDD);
        issue(32'h8, 1'b1, 4'hF, 32'h55667788);
        issue(32'h6, 1'b0, 4'hF, 32'h0);
        @(negedge clk);
        check("split_gnt_low", 64'(gnt_o), 64'd0);
        drain();

        // Partial-strobe writes, split and single beat, plus a no-strobe write
        issue(32'h7, 1'b1, 4'b0011, 32'hDEADBEEF);
        issue(32'h5, 1'b1, 4'b0011, 32'h0000EEFF);
        issue(32'hC, 1'b1, 4'b0000, 32'hFFFFFFFF);
        issue(32'h4, 1'b0, 4'h0, 32'h0);
        issue(32'h8, 1'b0, 4'h0, 32'h0);
        issue(32'hC, 1'b0, 4'h0, 32'h0);
        drain();

        // Range errors, including a straddle off the top and high address bits
        issue(32'h3E, 1'b0, 4'hF, 32'h0);
        issue(32'h40, 1'b1, 4'hF, 32'h12345678);
        issue(32'h3E, 1'b1, 4'hF, 32'hCAFEF00D);
        issue(32'h100, 1'b1, 4'hF, 32'h0BADBEEF);
        issue(32'h8000_0000, 1'b0, 4'hF, 32'h0);
        issue(32'h3C, 1'b0, 4'h0, 32'h0);
        issue(32'h0, 1'b0, 4'h0, 32'h0);
        drain();

        // Back-to-back aligned reads
        issue(32'h0, 1'b0, 4'h0, 32'h0);
        issue(32'h4, 1'b0, 4'h0, 32'h0);
        issue(32'h8, 1'b0, 4'h0, 32'h0);
        drain();

        // Reset during the second beat of a straddling write: only the first beat lands
        wd = $urandom;
        @(negedge clk);
        req_i   = 1'b1;
        addr_i  = 32'h6;
        we_i    = 1'b1;
        be_i    = 4'hF;
        wdata_i = wd;
        check("pre_reset_gnt", 64'(gnt_o), 64'd1);
        mem_m[6] = wd[7:0];
        mem_m[7] = wd[15:8];
        @(posedge clk);
        #1 req_i = 1'b0;
        @(negedge clk);
        check("mid_split_gnt", 64'(gnt_o), 64'd0);
        rstn_i = 1'b0;
        #1;
        check("mid_reset_gnt", 64'(gnt_o), 64'd1);
        check("mid_reset_rvalid", 64'(rvalid_o), 64'd0);
        check("mid_reset_rdata", 64'(rdata_o), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rstn_i = 1'b1;
        repeat (3) @(negedge clk);
        issue(32'h4, 1'b0, 4'h0, 32'h0);
        issue(32'h8, 1'b0, 4'h0, 32'h0);
        drain();

        // Randomized traffic across aligned, straddling and out-of-range addresses
        for (int i = 0; i < 300; i++) begin
            a = 32'($urandom_range(0, MEM_BYTES + 7));
            if ($urandom_range(0, 15) == 0) a = $urandom;
            issue(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();

        for (int w = 0; w < DEPTH; w++) issue(32'(w * 4), 1'b0, 4'h0, 32'h0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
